// File: rtl/hamming_codec_pipe.sv
// Pipelined Hamming codec: encode or single-error-correcting decode, selected per beat.
// Two register stages with valid/ready on both sides and saturating error counters.
// Define HAMMING_SECDED_EN to add an overall-parity bit (SECDED, word width CW+1).
module hamming_codec_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16,
    // Smallest P with 2^P >= DATA_W+P+1, valid over DATA_W = 4..57
    localparam int unsigned P  = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
    localparam int unsigned CW = DATA_W + P,
`ifdef HAMMING_SECDED_EN
    localparam int unsigned WW = CW + 1
`else
    localparam int unsigned WW = CW
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WW-1:0]    in_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WW-1:0]    out_word,
    output logic [P-1:0]     out_syndrome,
    output logic             out_corr,
    output logic             out_uncorr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [P-1:0] CW_S = P'(CW);

    // XOR of the 1-based positions of all set bits
    function automatic logic [P-1:0] calc_syn(input logic [CW-1:0] w);
        logic [P-1:0] s;
        s = '0;
        for (int i = 0; i < CW; i++) begin
            if (w[i]) s = s ^ P'(i + 1);
        end
        return s;
    endfunction

    // Place payload bits at non-power-of-two positions, parity slots left 0
    function automatic logic [CW-1:0] scatter(input logic [DATA_W-1:0] d);
        logic [CW-1:0] w;
        int j;
        w = '0;
        j = 0;
        for (int i = 0; i < CW; i++) begin
            if (((i + 1) & i) != 0) begin
                w[i] = d[j];
                j++;
            end
        end
        return w;
    endfunction

    // Pull payload bits back out of the data positions
    function automatic logic [DATA_W-1:0] gather(input logic [CW-1:0] w);
        logic [DATA_W-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 0; i < CW; i++) begin
            if (((i + 1) & i) != 0) begin
                d[j] = w[i];
                j++;
            end
        end
        return d;
    endfunction

    logic             s1_valid_q, s1_mode_q;
    logic [WW-1:0]    s1_word_q;
    logic             s2_valid_q, s2_mode_q, s2_corr_q, s2_uncorr_q;
    logic [WW-1:0]    s2_word_q;
    logic [P-1:0]     s2_syn_q;
    logic [CNT_W-1:0] corr_cnt_q, uncorr_cnt_q;

    logic             s1_adv, in_fire, out_fire;
    logic [CW-1:0]    enc_cw, dec_cw;
    logic [P-1:0]     enc_syn, dec_syn;
    logic             flip;
    logic [WW-1:0]    res_word;
    logic [P-1:0]     res_syn;
    logic             res_corr, res_uncorr;

    assign s1_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s1_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    // With parity slots zero, the syndrome of the scattered word is exactly the parity vector
    assign enc_syn = calc_syn(scatter(s1_word_q[DATA_W-1:0]));
    assign dec_syn = calc_syn(s1_word_q[CW-1:0]);

    // Compute the result for the beat held in stage 1
    always_comb begin
        res_word   = '0;
        res_syn    = '0;
        res_corr   = 1'b0;
        res_uncorr = 1'b0;
        flip       = 1'b0;
        enc_cw     = scatter(s1_word_q[DATA_W-1:0]);
        dec_cw     = s1_word_q[CW-1:0];
        if (!s1_mode_q) begin
            for (int k = 0; k < P; k++) begin
                enc_cw[(1 << k) - 1] = enc_syn[k];
            end
            res_word[CW-1:0] = enc_cw;
`ifdef HAMMING_SECDED_EN
            res_word[CW] = ^enc_cw;
`endif
        end else begin
            res_syn = dec_syn;
`ifdef HAMMING_SECDED_EN
            // Odd overall parity means one error; S=0 then points at the parity bit itself
            if (^s1_word_q) begin
                if (dec_syn > CW_S) begin
                    res_uncorr = 1'b1;
                end else begin
                    res_corr = 1'b1;
                    flip     = (dec_syn != '0);
                end
            end else if (dec_syn != '0) begin
                res_uncorr = 1'b1;
            end
`else
            if (dec_syn > CW_S) begin
                res_uncorr = 1'b1;
            end else if (dec_syn != '0) begin
                res_corr = 1'b1;
                flip     = 1'b1;
            end
`endif
            for (int i = 0; i < CW; i++) begin
                if (flip && dec_syn == P'(i + 1)) dec_cw[i] = ~dec_cw[i];
            end
            res_word[DATA_W-1:0] = gather(dec_cw);
        end
    end

    // Stage 1: capture the accepted input beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_word_q  <= '0;
        end else begin
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_mode_q  <= in_mode;
                s1_word_q  <= in_word;
            end else if (s1_adv) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    // Stage 2: hold the computed result; stalls keep every output stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_mode_q   <= 1'b0;
            s2_word_q   <= '0;
            s2_syn_q    <= '0;
            s2_corr_q   <= 1'b0;
            s2_uncorr_q <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_valid_q  <= 1'b1;
                s2_mode_q   <= s1_mode_q;
                s2_word_q   <= res_word;
                s2_syn_q    <= res_syn;
                s2_corr_q   <= res_corr;
                s2_uncorr_q <= res_uncorr;
            end else if (out_ready) begin
                s2_valid_q <= 1'b0;
            end
        end
    end

    // Saturating error counters, clear takes priority over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (cnt_clr) begin
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else if (out_fire && s2_mode_q) begin
            if (s2_corr_q && corr_cnt_q != '1) corr_cnt_q <= corr_cnt_q + 1'b1;
            if (s2_uncorr_q && uncorr_cnt_q != '1) uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_mode     = s2_mode_q;
    assign out_word     = s2_word_q;
    assign out_syndrome = s2_syn_q;
    assign out_corr     = s2_corr_q;
    assign out_uncorr   = s2_uncorr_q;
    assign corr_cnt     = corr_cnt_q;
    assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_codec_pipe.sv
// Self-checking bench for hamming_codec_pipe (DATA_W=8, CNT_W=16).
// Honours HAMMING_SECDED_EN the same way as the design.
module tb_hamming_codec_pipe;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int P      = 4;
    localparam int CW     = 12;
`ifdef HAMMING_SECDED_EN
    localparam int WW       = 13;
    localparam int TBL_CORR = 4;
`else
    localparam int WW       = 12;
    localparam int TBL_CORR = 3;
`endif

    typedef struct {
        logic          mode;
        logic [WW-1:0] word;
        logic [P-1:0]  syn;
        logic          corr;
        logic          uncorr;
    } exp_t;

    typedef struct {
        logic          mode;
        logic [WW-1:0] din;
        exp_t          e;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready, in_mode;
    logic [WW-1:0]    in_word;
    logic             out_valid, out_ready, out_mode;
    logic [WW-1:0]    out_word;
    logic [P-1:0]     out_syndrome;
    logic             out_corr, out_uncorr, cnt_clr;
    logic [CNT_W-1:0] corr_cnt, uncorr_cnt;

    int checks   = 0;
    int failures = 0;

    exp_t exp_q[$];
    vec_t vecs[$];

    hamming_codec_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mode      (in_mode),
        .in_word      (in_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_mode     (out_mode),
        .out_word     (out_word),
        .out_syndrome (out_syndrome),
        .out_corr     (out_corr),
        .out_uncorr   (out_uncorr),
        .cnt_clr      (cnt_clr),
        .corr_cnt     (corr_cnt),
        .uncorr_cnt   (uncorr_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: parity k checks every position with bit k set
    function automatic logic [WW-1:0] m_encode(input logic [DATA_W-1:0] d);
        logic [WW-1:0] w;
        logic par;
        int j;
        w = '0;
        j = 0;
        for (int pos = 1; pos <= CW; pos++) begin
            if ($countones(pos) != 1) begin
                w[pos-1] = d[j];
                j++;
            end
        end
        for (int k = 0; k < P; k++) begin
            par = 1'b0;
            for (int pos = 1; pos <= CW; pos++) begin
                if (((pos >> k) & 1) == 1 && pos != (1 << k)) par ^= w[pos-1];
            end
            w[(1 << k) - 1] = par;
        end
`ifdef HAMMING_SECDED_EN
        w[CW] = ^w[CW-1:0];
`endif
        return w;
    endfunction

    function automatic exp_t m_decode(input logic [WW-1:0] w);
        exp_t e;
        logic [CW-1:0] c;
        logic par, flip;
        int s, j;
        s = 0;
        for (int k = 0; k < P; k++) begin
            par = 1'b0;
            for (int pos = 1; pos <= CW; pos++) begin
                if (((pos >> k) & 1) == 1) par ^= w[pos-1];
            end
            if (par) s += (1 << k);
        end
        e.mode = 1'b1;
        e.corr = 1'b0;
        e.uncorr = 1'b0;
        flip = 1'b0;
`ifdef HAMMING_SECDED_EN
        if (^w) begin
            if (s > CW) e.uncorr = 1'b1;
            else begin
                e.corr = 1'b1;
                flip = (s != 0);
            end
        end else if (s != 0) e.uncorr = 1'b1;
`else
        if (s > CW) e.uncorr = 1'b1;
        else if (s != 0) begin
            e.corr = 1'b1;
            flip = 1'b1;
        end
`endif
        c = w[CW-1:0];
        if (flip) c[s-1] = ~c[s-1];
        e.word = '0;
        j = 0;
        for (int pos = 1; pos <= CW; pos++) begin
            if ($countones(pos) != 1) begin
                e.word[j] = c[pos-1];
                j++;
            end
        end
        e.syn = P'(s);
        return e;
    endfunction

    function automatic exp_t mk_exp(input logic m, input logic [WW-1:0] w, input logic [P-1:0] s,
                                    input logic c, input logic u);
        exp_t e;
        e.mode = m;
        e.word = w;
        e.syn = s;
        e.corr = c;
        e.uncorr = u;
        return e;
    endfunction

    function automatic exp_t enc_exp(input logic [DATA_W-1:0] d);
        return mk_exp(1'b0, m_encode(d), '0, 1'b0, 1'b0);
    endfunction

    task automatic add_vec(input logic m, input logic [WW-1:0] din, input logic [WW-1:0] w,
                           input logic [P-1:0] s, input logic c, input logic u);
        vec_t v;
        v.mode = m;
        v.din = din;
        v.e = mk_exp(m, w, s, c, u);
        vecs.push_back(v);
    endtask

    // Drive one beat, push its expectation at the handshake; returns at posedge+1
    task automatic send(input logic m, input logic [WW-1:0] w, input exp_t e);
        int n;
        in_valid = 1'b1;
        in_mode = m;
        in_word = w;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard, stall stability, in_ready and counter model
    int               occ;
    logic             prev_stall;
    logic             snap_mode, snap_corr, snap_uncorr;
    logic [WW-1:0]    snap_word;
    logic [P-1:0]     snap_syn;
    logic [CNT_W-1:0] m_corr, m_uncorr, n_corr, n_uncorr;
    exp_t             me;

    always @(negedge clk) begin
        if (!rst_n) begin
            occ = 0;
            prev_stall = 1'b0;
            m_corr = '0;
            m_uncorr = '0;
        end else begin
            chk("in_ready", in_ready, (occ < 2) || out_ready);
            chk("corr_cnt", corr_cnt, m_corr);
            chk("uncorr_cnt", uncorr_cnt, m_uncorr);
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_mode", out_mode, snap_mode);
                chk("hold_word", out_word, snap_word);
                chk("hold_syn", out_syndrome, snap_syn);
                chk("hold_corr", out_corr, snap_corr);
                chk("hold_uncorr", out_uncorr, snap_uncorr);
            end
            n_corr = m_corr;
            n_uncorr = m_uncorr;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out: word %0h with no beat pending", out_word);
                end else begin
                    me = exp_q.pop_front();
                    chk("out_mode", out_mode, me.mode);
                    chk("out_word", out_word, me.word);
                    chk("out_syndrome", out_syndrome, me.syn);
                    chk("out_corr", out_corr, me.corr);
                    chk("out_uncorr", out_uncorr, me.uncorr);
                    if (me.mode && me.corr && m_corr != '1) n_corr = m_corr + 1'b1;
                    if (me.mode && me.uncorr && m_uncorr != '1) n_uncorr = m_uncorr + 1'b1;
                end
                occ--;
            end
            if (in_valid && in_ready) occ++;
            if (cnt_clr) begin
                n_corr = '0;
                n_uncorr = '0;
            end
            m_corr = n_corr;
            m_uncorr = n_uncorr;
            prev_stall = out_valid && !out_ready;
            snap_mode = out_mode;
            snap_word = out_word;
            snap_syn = out_syndrome;
            snap_corr = out_corr;
            snap_uncorr = out_uncorr;
        end
    end

    logic stream_done;
    exp_t ce;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_mode = 1'b0;
        in_word = '0;
        out_ready = 1'b1;
        cnt_clr = 1'b0;

        add_vec(1'b0, WW'(12'h0A5), WW'(12'hA27), 4'd0,  1'b0, 1'b0);
        add_vec(1'b0, WW'(12'hFA5), WW'(12'hA27), 4'd0,  1'b0, 1'b0);
        add_vec(1'b0, WW'(12'h000), WW'(12'h000), 4'd0,  1'b0, 1'b0);
        add_vec(1'b0, WW'(12'h0FF), WW'(12'hF77), 4'd0,  1'b0, 1'b0);
        add_vec(1'b1, WW'(12'hA27), WW'(12'h0A5), 4'd0,  1'b0, 1'b0);
        add_vec(1'b1, WW'(12'hA07), WW'(12'h0A5), 4'd6,  1'b1, 1'b0);
        add_vec(1'b1, WW'(12'hA26), WW'(12'h0A5), 4'd1,  1'b1, 1'b0);
        add_vec(1'b1, WW'(12'h777), WW'(12'h0FF), 4'd12, 1'b1, 1'b0);
        add_vec(1'b1, WW'(12'h226), WW'(12'h025), 4'd13, 1'b0, 1'b1);
`ifdef HAMMING_SECDED_EN
        add_vec(1'b1, WW'(13'h1A27), WW'(12'h0A5), 4'd0, 1'b1, 1'b0);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_word", out_word, '0);
        chk("rst_out_syn", out_syndrome, '0);
        chk("rst_out_flags", {out_mode, out_corr, out_uncorr}, 3'b000);
        chk("rst_corr_cnt", corr_cnt, '0);
        chk("rst_uncorr_cnt", uncorr_cnt, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Latency: result appears two cycles after accept
        send(1'b0, WW'(12'h0A5), mk_exp(1'b0, WW'(12'hA27), '0, 1'b0, 1'b0));
        chk("lat_valid_c1", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_valid_c2", out_valid, 1'b1);
        chk("lat_word_c2", out_word, WW'(12'hA27));
        drain();

        // Table vectors, back to back
        foreach (vecs[i]) send(vecs[i].mode, vecs[i].din, vecs[i].e);
        drain();
        chk("tbl_corr_cnt", corr_cnt, CNT_W'(TBL_CORR));
        chk("tbl_uncorr_cnt", uncorr_cnt, CNT_W'(1));

        // Alternating stream under a 1,0,0,1 out_ready pattern
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [DATA_W-1:0] d;
                    logic [WW-1:0] w;
                    int b0, b1;
                    d = DATA_W'($urandom_range(0, 255));
                    if (i % 2 == 0) begin
                        send(1'b0, WW'(d), enc_exp(d));
                    end else begin
                        w = m_encode(d);
                        b0 = $urandom_range(0, CW - 1);
                        b1 = (b0 + 1 + $urandom_range(0, CW - 2)) % CW;
                        w[b0] = ~w[b0];
                        if (i % 4 == 3) w[b1] = ~w[b1];
                        send(1'b1, w, m_decode(w));
                    end
                end
                stream_done = 1'b1;
            end
            begin
                for (int c = 0; c < 80 && !(stream_done && exp_q.size() == 0); c++) begin
                    out_ready = (c % 4 == 0) || (c % 4 == 3);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Saturation of corr_cnt
        ce = mk_exp(1'b1, WW'(12'h0A5), 4'd6, 1'b1, 1'b0);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_corr_cnt", corr_cnt, '0);
        chk("clr_uncorr_cnt", uncorr_cnt, '0);
        for (int i = 0; i < 65534; i++) send(1'b1, WW'(12'hA07), ce);
        drain();
        chk("sat_pre", corr_cnt, 16'hFFFE);
        send(1'b1, WW'(12'hA07), ce);
        send(1'b1, WW'(12'hA07), ce);
        drain();
        chk("sat_max", corr_cnt, 16'hFFFF);
        send(1'b1, WW'(12'hA07), ce);
        drain();
        chk("sat_hold", corr_cnt, 16'hFFFF);

        // Clear coinciding with an increment
        out_ready = 1'b0;
        send(1'b1, WW'(12'hA07), ce);
        for (int n = 0; n < 10 && !out_valid; n++) begin
            @(posedge clk);
            #1;
        end
        chk("clr_inc_valid", out_valid, 1'b1);
        cnt_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_wins", corr_cnt, '0);
        drain();

        // Reset with two beats in flight
        out_ready = 1'b0;
        send(1'b0, WW'(12'h011), enc_exp(8'h11));
        send(1'b1, WW'(12'hA07), ce);
        @(posedge clk);
        #1;
        chk("inflight_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_word", out_word, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(1'b0, WW'(12'h000), mk_exp(1'b0, WW'(12'h000), '0, 1'b0, 1'b0));
        drain();
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_valid", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hamming_codec_pipe.md
Name: hamming_codec_pipe

Overview:
- Parametrised, pipelined Hamming codec for the FSK link. Encodes DATA_W-bit payloads into codewords, or decodes codewords with single-error correction, selected per beat.
- Sits between the framing logic and the FSK modulator/demodulator.
- Uses valid/ready handshakes on both sides and keeps saturating error statistics.

Parameters:
- DATA_W, 8: payload width, 4..57.
- CNT_W, 16: width of each error counter.
- Derived P: smallest integer with 2^P >= DATA_W+P+1. Gives P=4 for DATA_W=8.
- Derived CW = DATA_W+P: base codeword width, 12 for DATA_W=8.
- Derived WW = CW, or CW+1 with HAMMING_SECDED_EN: bus word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  codec can accept a beat.
- in_mode  in  1  0 = encode, 1 = decode; sampled with the beat.
- in_word  in  WW  encode: payload in [DATA_W-1:0], upper bits ignored; decode: received codeword.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_mode  out  1  mode of the beat being presented.
- out_word  out  WW  encode: codeword; decode: corrected payload in [DATA_W-1:0], upper bits 0.
- out_syndrome  out  P  decode syndrome; 0 on encode beats.
- out_corr  out  1  decode beat had a single error, which was corrected.
- out_uncorr  out  1  decode beat uncorrectable; payload passed uncorrected.
- cnt_clr  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  count of accepted corrected beats, saturating.
- uncorr_cnt  out  CNT_W  count of accepted uncorrectable beats, saturating.

Behaviour:
- Codeword layout:
  - Bit index i holds Hamming position i+1.
  - Parity bits sit at positions 2^k, k=0..P-1.
  - Payload bits fill the remaining positions in ascending order, data[0] at the lowest.
- Encode: parity at position 2^k = XOR of all other positions whose index has bit k set (even parity).
- Decode:
  - Syndrome S = XOR of the position numbers of all set bits.
  - S=0: clean.
  - 1 <= S <= CW: flip position S and set out_corr.
  - S > CW: set out_uncorr, no flip.
  - Extract payload from data positions.
- Pipeline:
  - Two register stages: S1 captures the input beat; S2 holds the computed result and drives out_*.
  - A stage advances when its successor is empty or advancing.
  - in_ready = !s1_valid | s1_adv. No combinational path from in_valid to out_valid.
- Latency and throughput:
  - Latency 2 cycles from the in handshake to out_valid, with out_ready held high.
  - Throughput 1 beat/cycle.
- Output hold: while out_valid && !out_ready, all out_* hold stable and both stages stall.
- Beat handling:
  - Beats are never dropped or duplicated; order is preserved.
  - Mode may change every beat.
- Counters:
  - corr_cnt or uncorr_cnt increments on an output handshake (out_valid & out_ready) of a decode beat with the matching flag.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr in the same cycle as an increment: clear wins, counter = 0.
- Reset (async assert, sync release): all valids 0, out_word/out_syndrome/out_corr/out_uncorr/out_mode 0, counters 0, in_ready 1 after release.
- Reset mid-operation discards every in-flight beat.

Optional Feature:
- Macro: HAMMING_SECDED_EN.
- When defined:
  - WW = CW+1; bit CW carries overall even parity across bits [CW-1:0].
  - Decode with S != 0 and overall parity correct is a double error: out_uncorr=1, no flip.
  - Decode with overall parity wrong: single error. If S=0 the error is in bit CW itself, so out_corr=1 and the payload is unchanged.
- When undefined: WW = CW, no overall-parity logic, S>CW is the only uncorrectable case.

Test Plan:
- DATA_W=8, encode 8'hA5 -> out_word 12'hA27 two cycles after accept, syndrome 0, corr=uncorr=0.
- Decode 12'hA07 (bit 5 flipped) -> syndrome 6, out_corr=1, out_word[7:0]=8'hA5, corr_cnt 0->1.
- Decode 12'h226 (positions 1 and 12 flipped) -> syndrome 13, out_uncorr=1, uncorr_cnt +1. Under SECDED, 13'h0226 -> out_uncorr=1.
- Stream 8 alternating encode/decode beats with out_ready toggling 1,0,0,1,... -> all 8 results in order, out_* stable while stalled, in_ready low only when both stages are full.
- Preload corr_cnt to 16'hFFFE via repeated correctable beats; two more corrected beats -> 16'hFFFF holds. cnt_clr together with an increment -> 0.
- Assert rst_n low with 2 beats in flight -> out_valid=0 immediately. After release, a new beat 8'h00 encodes to 12'h000 with no stale output.
